// File: rtl/scale_rate_adapter_pkg.sv
// Shared ISP definitions: divider range limits and the tag word carried alongside each pixel.
package scale_rate_adapter_pkg;

  localparam int DIV_MIN = 1;
  localparam int DIV_MAX = 8;
  localparam int CNT_W   = $clog2(DIV_MAX);

  typedef struct packed {
    logic sof;
    logic eol;
  } tag_t;

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/scale_sync_fifo.sv
// Synchronous FIFO with flush, occupancy count and a registered read port (updated only on pop).
// head_peek_o exposes the top bits of the head word so the caller can inspect tags before popping.
module scale_sync_fifo
  import scale_rate_adapter_pkg::*;
#(
  parameter int WIDTH  = 18,
  parameter int DEPTH  = 8,
  parameter int PEEK_W = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  input  logic                   pop_i,
  output logic [PEEK_W-1:0]      head_peek_o,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("scale_sync_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             push_ok, pop_ok;
  logic [WIDTH-1:0] head_word;

  assign full_o      = (level_q == FULL_LVL);
  assign empty_o     = (level_q == '0);
  assign push_ok     = push_i & ~full_o & ~flush_i;
  assign pop_ok      = pop_i & ~empty_o & ~flush_i;
  assign head_word   = mem_q[rd_ptr_q];
  assign head_peek_o = head_word[WIDTH-1 -: PEEK_W];
  assign rd_data_o   = rd_data_q;
  assign level_o     = level_q;

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        rd_data_q <= head_word;
      end
      if (push_ok && !pop_ok)      level_q <= level_q + 1'b1;
      else if (pop_ok && !push_ok) level_q <= level_q - 1'b1;
    end
  end

endmodule

// File: rtl/scale_rate_adapter.sv
// Pixel pacer: buffers the input stream and re-issues one pixel per CLK_DIVIDER pclk cycles with a
// matching scale_ce strobe. in_ready falls only when the FIFO is full; nothing is dropped except on flush/rst.
module scale_rate_adapter
  import scale_rate_adapter_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int CLK_DIVIDER = 1,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                        pclk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        flush,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic                        in_sof,
  input  logic                        in_eol,
  output logic                        in_ready,
  output logic                        scale_ce,
  output logic                        out_valid,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_sof,
  output logic                        out_eol,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        underrun
);

  if (CLK_DIVIDER < DIV_MIN || CLK_DIVIDER > DIV_MAX) begin : g_bad_div
    $error("scale_rate_adapter: CLK_DIVIDER out of range");
  end

  localparam int W = DATA_WIDTH + 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIVIDER - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick, push, pop;
  logic             scale_ce_q, out_valid_q, frame_active_q, underrun_q;
  logic             fifo_full, fifo_empty;
  tag_t             in_tag, head_tag, rd_tag;
  logic [1:0]       head_peek;
  logic [W-1:0]     wr_word, rd_word;

  assign tick     = en & (cnt_q == CNT_LAST);
  assign in_ready = ~fifo_full;
  assign push     = in_valid & in_ready & ~flush;
  assign pop      = tick & ~fifo_empty & ~flush;

  assign in_tag   = '{sof: in_sof, eol: in_eol};
  assign wr_word  = {in_tag, in_data};
  assign head_tag = tag_t'(head_peek);
  assign rd_tag   = tag_t'(rd_word[DATA_WIDTH +: 2]);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (flush || !en || tick) cnt_d = '0;
  end

  scale_sync_fifo #(
    .WIDTH  (W),
    .DEPTH  (FIFO_DEPTH),
    .PEEK_W (2)
  ) u_fifo (
    .clk_i       (pclk),
    .rst_i       (rst),
    .flush_i     (flush),
    .push_i      (push),
    .wr_data_i   (wr_word),
    .pop_i       (pop),
    .head_peek_o (head_peek),
    .rd_data_o   (rd_word),
    .level_o     (fifo_level),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      cnt_q          <= '0;
      scale_ce_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      frame_active_q <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (flush) begin
        scale_ce_q     <= 1'b0;
        out_valid_q    <= 1'b0;
        frame_active_q <= 1'b0;
      end else begin
        scale_ce_q  <= tick;
        out_valid_q <= pop;
        if (tick && fifo_empty && frame_active_q) underrun_q <= 1'b1;
        // A newly accepted sof outranks an eol leaving in the same cycle: it opens the next frame.
        if (push && in_sof)             frame_active_q <= 1'b1;
        else if (pop && head_tag.eol)   frame_active_q <= 1'b0;
      end
    end
  end

  assign scale_ce  = scale_ce_q;
  assign out_valid = out_valid_q;
  assign out_data  = rd_word[DATA_WIDTH-1:0];
  assign out_sof   = rd_tag.sof;
  assign out_eol   = rd_tag.eol;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_scale_rate_adapter.sv
// Four pacers (CLK_DIVIDER 1..4) share one stimulus stream; a queue-based reference model predicts
// every output each cycle, alongside a directed vector table and hand-written corner-case sequences.
module tb_scale_rate_adapter;

  localparam int NI    = 4;
  localparam int DEPTH = 8;

  logic pclk = 1'b0;
  logic rst, en, flush, in_valid, in_sof, in_eol;
  logic [15:0] in_data;

  logic [NI-1:0] in_ready_w, ce_w, ov_w, sof_w, eol_w, ur_w;
  logic [15:0]   data_w [NI];
  logic [3:0]    lvl_w  [NI];

  always #5 pclk = ~pclk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    scale_rate_adapter #(
      .DATA_WIDTH  (16),
      .CLK_DIVIDER (g + 1),
      .FIFO_DEPTH  (DEPTH)
    ) u_dut (
      .pclk       (pclk),
      .rst        (rst),
      .en         (en),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_sof     (in_sof),
      .in_eol     (in_eol),
      .in_ready   (in_ready_w[g]),
      .scale_ce   (ce_w[g]),
      .out_valid  (ov_w[g]),
      .out_data   (data_w[g]),
      .out_sof    (sof_w[g]),
      .out_eol    (eol_w[g]),
      .fifo_level (lvl_w[g]),
      .underrun   (ur_w[g])
    );
  end

  // Reference model: per instance a ring of {eol, sof, data} words plus the divider phase.
  logic [17:0]   mbuf [NI][64];
  int            mhead [NI];
  int            mtail [NI];
  int            mcnt  [NI];
  logic [NI-1:0] m_ce, m_ov, m_sof, m_eol, m_ur, m_fa, acc;
  logic [15:0]   m_data [NI];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", nm, idx, act, req);
    end
  endtask

  function automatic logic [31:0] dut_outs(input int i);
    return {7'b0, ce_w[i], ov_w[i], sof_w[i], eol_w[i], ur_w[i], lvl_w[i], data_w[i]};
  endfunction

  function automatic logic [31:0] model_outs(input int i);
    return {7'b0, m_ce[i], m_ov[i], m_sof[i], m_eol[i], m_ur[i], 4'(mtail[i] - mhead[i]), m_data[i]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      mhead[i]  = 0;
      mtail[i]  = 0;
      mcnt[i]   = 0;
      m_data[i] = 16'h0;
    end
    m_ce = '0; m_ov = '0; m_sof = '0; m_eol = '0; m_ur = '0; m_fa = '0; acc = '0;
  endtask

  // One rising edge of the reference: instance i paces at one slot per (i+1) cycles.
  task automatic model_edge();
    for (int i = 0; i < NI; i++) begin
      int lvl;
      bit tick;
      logic [17:0] w;
      lvl    = mtail[i] - mhead[i];
      tick   = en && (mcnt[i] == i);
      acc[i] = 1'b0;
      if (flush) begin
        mhead[i] = mtail[i];
        mcnt[i]  = 0;
        m_ce[i]  = 1'b0;
        m_ov[i]  = 1'b0;
        m_fa[i]  = 1'b0;
      end else begin
        m_ce[i] = tick;
        m_ov[i] = 1'b0;
        if (tick && lvl > 0) begin
          w         = mbuf[i][6'(mhead[i])];
          mhead[i]  = mhead[i] + 1;
          m_ov[i]   = 1'b1;
          m_data[i] = w[15:0];
          m_sof[i]  = w[16];
          m_eol[i]  = w[17];
          if (w[17]) m_fa[i] = 1'b0;
        end else if (tick && m_fa[i]) begin
          m_ur[i] = 1'b1;
        end
        if (in_valid && lvl < DEPTH) begin
          mbuf[i][6'(mtail[i])] = {in_eol, in_sof, in_data};
          mtail[i] = mtail[i] + 1;
          acc[i]   = 1'b1;
          if (in_sof) m_fa[i] = 1'b1;
        end
        mcnt[i] = !en ? 0 : (mcnt[i] == i) ? 0 : mcnt[i] + 1;
      end
    end
  endtask

  task automatic step();
    for (int i = 0; i < NI; i++)
      chk("in_ready", i, 32'(in_ready_w[i]), 32'(mtail[i] - mhead[i] < DEPTH));
    @(posedge pclk);
    model_edge();
    #1;
    for (int i = 0; i < NI; i++) chk("outs", i, dut_outs(i), model_outs(i));
  endtask

  task automatic do_reset();
    en = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 16'h0; in_sof = 1'b0; in_eol = 1'b0;
    rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) chk("rst_outs", i, dut_outs(i), 32'h0);
    model_reset();
    repeat (2) @(posedge pclk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < NI; i++) chk("rst_ready", i, 32'(in_ready_w[i]), 32'h1);
  endtask

  typedef struct {
    logic en, flush, vld;
    logic [15:0] d;
    logic sof, eol;
    logic e_rdy, e_ce, e_ov;
    logic [15:0] e_d;
    logic [3:0] e_lvl;
  } vec_t;

  vec_t tbl [11];
  int k, nexp, last, nce, n;
  bit found;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Expected values for the CLK_DIVIDER=1 instance, starting right after reset.
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 16'h11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h00, 4'd1};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 16'h12, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h11, 4'd1};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 16'h13, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h12, 4'd1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 16'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h13, 4'd0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 16'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h13, 4'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 16'h21, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h13, 4'd1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 16'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h13, 4'd1};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 16'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h21, 4'd0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 16'h31, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h21, 4'd0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 16'h32, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h21, 4'd1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 16'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h32, 4'd0};

    do_reset();
    for (int r = 0; r < 11; r++) begin
      en = tbl[r].en; flush = tbl[r].flush; in_valid = tbl[r].vld;
      in_data = tbl[r].d; in_sof = tbl[r].sof; in_eol = tbl[r].eol;
      chk("tbl_rdy", r, 32'(in_ready_w[0]), 32'(tbl[r].e_rdy));
      step();
      chk("tbl_ce", r, 32'(ce_w[0]), 32'(tbl[r].e_ce));
      chk("tbl_ov", r, 32'(ov_w[0]), 32'(tbl[r].e_ov));
      chk("tbl_data", r, 32'(data_w[0]), 32'(tbl[r].e_d));
      chk("tbl_lvl", r, 32'(lvl_w[0]), 32'(tbl[r].e_lvl));
      chk("tbl_ur", r, 32'(ur_w[0]), 32'h0);
    end

    // 8 tagged pixels through the divide-by-4 instance: order, tags, 4-cycle spacing.
    do_reset();
    en = 1'b1; k = 1; nexp = 1; last = 0;
    for (int c = 1; c <= 100 && nexp <= 8; c++) begin
      in_valid = (k <= 8); in_data = 16'(k); in_sof = (k == 1); in_eol = (k == 8);
      step();
      if (acc[3]) k++;
      if (ov_w[3]) begin
        chk("t1_data", nexp, 32'(data_w[3]), 32'(nexp));
        chk("t1_tags", nexp, 32'({sof_w[3], eol_w[3]}), 32'({nexp == 1, nexp == 8}));
        if (nexp > 1) chk("t1_gap", nexp, 32'(c - last), 32'd4);
        last = c;
        nexp++;
      end
    end
    chk("t1_count", 3, 32'(nexp), 32'd9);

    // Full FIFO on the divide-by-3 instance with in_valid held high.
    do_reset();
    k = 0;
    for (int c = 0; c < 12; c++) begin
      in_valid = 1'b1; in_data = 16'(16'h100 + k);
      step();
      if (acc[2]) k++;
    end
    chk("t3_full_rdy", 2, 32'(in_ready_w[2]), 32'h0);
    chk("t3_full_lvl", 2, 32'(lvl_w[2]), 32'd8);
    en = 1'b1; nexp = 0;
    for (int c = 0; c < 60; c++) begin
      in_data = 16'(16'h100 + k);
      step();
      if (acc[2]) k++;
      if (ov_w[2]) begin
        chk("t3_order", nexp, 32'(data_w[2]), 32'(16'h100 + nexp));
        nexp++;
      end
    end
    in_valid = 1'b0;
    chk("t3_pops", 2, 32'(nexp), 32'd20);
    chk("t3_admits", 2, 32'(k), 32'd27);
    chk("t3_level", 2, 32'(lvl_w[2]), 32'(k - nexp));

    // en held low with 3 pixels queued, then released.
    do_reset();
    for (int j = 0; j < 3; j++) begin
      in_valid = 1'b1; in_data = 16'(16'h41 + j);
      step();
    end
    in_valid = 1'b0; nce = 0;
    repeat (10) begin
      step();
      if (|ce_w) nce++;
    end
    chk("t4_no_ce", 0, 32'(nce), 32'h0);
    en = 1'b1; found = 1'b0; n = 0;
    for (int c = 1; c <= 20 && !found; c++) begin
      step();
      if (ce_w[3]) begin found = 1'b1; n = c; end
    end
    chk("t4_first_ce", 3, 32'(n), 32'd4);
    chk("t4_first_pix", 3, 32'({ov_w[3], data_w[3]}), 32'({1'b1, 16'h41}));

    // sof accepted then input starved on the divide-by-2 instance.
    do_reset();
    en = 1'b1; in_valid = 1'b1; in_data = 16'h51; in_sof = 1'b1;
    step();
    in_valid = 1'b0; in_sof = 1'b0;
    step(); step();
    chk("t5_before", 1, 32'(ur_w[1]), 32'h0);
    step();
    chk("t5_set", 1, 32'(ur_w[1]), 32'h1);
    flush = 1'b1; step(); flush = 1'b0;
    chk("t5_after_flush", 1, 32'(ur_w[1]), 32'h1);
    repeat (4) step();
    chk("t5_hold", 1, 32'(ur_w[1]), 32'h1);
    do_reset();
    chk("t5_rst_clear", 1, 32'(ur_w[1]), 32'h0);

    // flush during a simultaneous push and pop, then rst mid-line.
    en = 1'b1; in_valid = 1'b1; in_data = 16'h61;
    step();
    in_data = 16'h62; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("t6_flush_lvl", 0, 32'(lvl_w[0]), 32'h0);
    chk("t6_flush_ov", 0, 32'(ov_w[0]), 32'h0);
    in_valid = 1'b1; in_data = 16'h63;
    step();
    in_valid = 1'b0;
    step();
    chk("t6_next_pix", 0, 32'({ov_w[0], data_w[0]}), 32'({1'b1, 16'h63}));
    in_valid = 1'b1; in_data = 16'h71; in_sof = 1'b1;
    step();
    in_data = 16'h72; in_sof = 1'b0;
    step();
    do_reset();
    en = 1'b1; in_valid = 1'b1; in_data = 16'h73;
    step();
    in_valid = 1'b0;
    step();
    chk("t6_rst_next_pix", 0, 32'({ov_w[0], data_w[0]}), 32'({1'b1, 16'h73}));

    // Randomized traffic with three input-rate phases to exercise empty, steady and full FIFOs.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int rate;
      rate     = ((c / 300) % 3 == 0) ? 3 : ((c / 300) % 3 == 1) ? 7 : 10;
      en       = ($urandom_range(0, 9) != 0);
      flush    = ($urandom_range(0, 59) == 0);
      in_valid = ($urandom_range(0, 9) < rate);
      in_data  = 16'($urandom);
      in_sof   = ($urandom_range(0, 9) == 0);
      in_eol   = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
